// File: rtl/usb_pkg.sv
// Shared constants and types for the USB endpoint datapath.
// The data buffer sizes its storage and pointers from these.
package usb_pkg;

    localparam int BUFFER_DEPTH    = 64;
    localparam int BUFFER_OCC_BITS = 7;

    typedef logic [7:0] byte_t;

endpackage : usb_pkg

// File: rtl/usb_data_buffer_if.sv
// Strobe/data bundle between the endpoint data buffer and its producers/consumers
// (AHB slave, USB receiver, USB transmitter).
//
// Strobe semantics: every store_*/get_* strobe is a single-cycle request sampled
// on the rising clock edge. There is no ready/acknowledge: a push while full
// (without a pop) or a pop while empty (without a push) is silently dropped, and
// callers consult buffer_occupancy beforehand. flush/clear empty the buffer on
// the next edge and override any push or pop in the same cycle.
interface usb_data_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OCC_BITS   = 7
);
    logic                  store_tx_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  store_rx_packet_data;
    logic [DATA_WIDTH-1:0] rx_packet_data;
    logic                  get_tx_packet_data;
    logic [DATA_WIDTH-1:0] tx_packet_data;
    logic                  get_rx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  flush;
    logic                  clear;
    logic [OCC_BITS-1:0]   buffer_occupancy;

    modport master (
        output store_tx_data, tx_data,
        output store_rx_packet_data, rx_packet_data,
        output get_tx_packet_data, get_rx_data,
        output flush, clear,
        input  tx_packet_data, rx_data, buffer_occupancy
    );

    modport slave (
        input  store_tx_data, tx_data,
        input  store_rx_packet_data, rx_packet_data,
        input  get_tx_packet_data, get_rx_data,
        input  flush, clear,
        output tx_packet_data, rx_data, buffer_occupancy
    );

endinterface : usb_data_buffer_if

// File: rtl/usb_buffer_ptr.sv
// Wrapping FIFO pointer: the low bits address storage, the MSB is the lap bit.
// A synchronous clear returns the pointer to zero and beats any increment.
module usb_buffer_ptr #(
    parameter int OCC_BITS = 7
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                inc,
    output logic [OCC_BITS-1:0] ptr
);

    logic [OCC_BITS-1:0] ptr_q;
    logic [OCC_BITS-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : usb_buffer_ptr

// File: rtl/usb_data_buffer.sv
// Shared first-word-fall-through byte FIFO feeding the USB transmitter and the AHB
// read path, filled by either the AHB slave or the USB receiver.
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH      = BUFFER_DEPTH,
    parameter int DATA_WIDTH = 8,
    parameter int OCC_BITS   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    usb_data_buffer_if.slave  bus
);

    localparam int ADDR_BITS = OCC_BITS - 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [OCC_BITS-1:0]   wptr;
    logic [OCC_BITS-1:0]   rptr;
    logic [OCC_BITS-1:0]   occupancy;
    logic                  full;
    logic                  empty;
    logic                  push_req;
    logic                  pop_req;
    logic                  empty_req;
    logic                  do_push;
    logic                  do_pop;
    logic [DATA_WIDTH-1:0] push_byte;

    // Pointer difference modulo 2*DEPTH distinguishes full from empty via the lap bit.
    assign occupancy = wptr - rptr;
    assign full      = (occupancy == OCC_BITS'(DEPTH));
    assign empty     = (occupancy == '0);

    assign push_req  = bus.store_rx_packet_data | bus.store_tx_data;
    assign pop_req   = bus.get_tx_packet_data | bus.get_rx_data;
    assign empty_req = bus.flush | bus.clear;

    // Receiver data wins a collision; the AHB byte is lost.
    assign push_byte = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;

    // At full a simultaneous pop frees the slot; at empty a simultaneous push is
    // stored but not bypassed, so the pop is dropped.
    assign do_push = push_req & (~full | pop_req) & ~empty_req;
    assign do_pop  = pop_req & ~empty & ~empty_req;

    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wptr[ADDR_BITS-1:0]] = push_byte;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    usb_buffer_ptr #(.OCC_BITS(OCC_BITS)) u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (empty_req),
        .inc   (do_push),
        .ptr   (wptr)
    );

    usb_buffer_ptr #(.OCC_BITS(OCC_BITS)) u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (empty_req),
        .inc   (do_pop),
        .ptr   (rptr)
    );

    assign bus.tx_packet_data   = mem_q[rptr[ADDR_BITS-1:0]];
    assign bus.rx_data          = mem_q[rptr[ADDR_BITS-1:0]];
    assign bus.buffer_occupancy = occupancy;

endmodule : usb_data_buffer

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer: a vector table for single-cycle behaviour
// plus hand sequences for fill/wrap, flush/clear and asynchronous reset.
module tb_usb_data_buffer;

  logic clk;
  logic n_rst;

  int n_checks;
  int n_fail;

  usb_data_buffer_if bus ();

  usb_data_buffer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s_tx;
    logic [7:0] d_tx;
    logic       s_rx;
    logic [7:0] d_rx;
    logic       g_tx;
    logic       g_rx;
    logic       fl;
    logic       cl;
    logic [6:0] exp_occ;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [6:0] occ, input logic [7:0] head);
    check({name, " occ"}, {1'b0, bus.buffer_occupancy}, {1'b0, occ});
    check({name, " tx_head"}, bus.tx_packet_data, head);
    check({name, " rx_head"}, bus.rx_data, head);
  endtask

  task automatic idle_inputs();
    bus.store_tx_data        = 1'b0;
    bus.tx_data              = 8'h00;
    bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data       = 8'h00;
    bus.get_tx_packet_data   = 1'b0;
    bus.get_rx_data          = 1'b0;
    bus.flush                = 1'b0;
    bus.clear                = 1'b0;
  endtask

  // driver: one-cycle stimulus applied at negedge, outputs settle #1 after posedge
  task automatic step(input logic s_tx, input logic [7:0] d_tx, input logic s_rx,
                      input logic [7:0] d_rx, input logic g_tx, input logic g_rx,
                      input logic fl, input logic cl);
    @(negedge clk);
    bus.store_tx_data        = s_tx;
    bus.tx_data              = d_tx;
    bus.store_rx_packet_data = s_rx;
    bus.rx_packet_data       = d_rx;
    bus.get_tx_packet_data   = g_tx;
    bus.get_rx_data          = g_rx;
    bus.flush                = fl;
    bus.clear                = cl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic push_tx(input logic [7:0] b);
    step(1'b1, b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_tx();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_vec(input logic s_tx, input logic [7:0] d_tx, input logic s_rx,
                         input logic [7:0] d_rx, input logic g_tx, input logic g_rx,
                         input logic [6:0] occ, input logic [7:0] head);
    vec_t v;
    v.s_tx = s_tx; v.d_tx = d_tx; v.s_rx = s_rx; v.d_rx = d_rx;
    v.g_tx = g_tx; v.g_rx = g_rx; v.fl = 1'b0; v.cl = 1'b0;
    v.exp_occ = occ; v.exp_head = head;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    n_rst = 1'b0;
    #1;
    check_state("reset", 7'd0, 8'h00);
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;

    // Basic FIFO, empty boundary and source collision; pointers start at 0.
    add_vec(1, 8'hA5, 0, 8'h00, 0, 0, 7'd1, 8'hA5);
    add_vec(1, 8'h3C, 0, 8'h00, 0, 0, 7'd2, 8'hA5);
    add_vec(1, 8'h7E, 0, 8'h00, 0, 0, 7'd3, 8'hA5);
    add_vec(0, 8'h00, 0, 8'h00, 1, 0, 7'd2, 8'h3C);
    add_vec(0, 8'h00, 0, 8'h00, 1, 0, 7'd1, 8'h7E);
    add_vec(0, 8'h00, 0, 8'h00, 1, 0, 7'd0, 8'h00);  // head now mem[3], never written
    add_vec(0, 8'h00, 0, 8'h00, 1, 0, 7'd0, 8'h00);  // pop at empty ignored
    add_vec(0, 8'h00, 0, 8'h00, 0, 1, 7'd0, 8'h00);
    add_vec(1, 8'h11, 0, 8'h00, 1, 0, 7'd1, 8'h11);  // push+pop at empty: push only
    add_vec(0, 8'h00, 0, 8'h00, 0, 1, 7'd0, 8'h00);
    add_vec(1, 8'hAA, 1, 8'h55, 0, 0, 7'd1, 8'h55);  // RX wins collision
    add_vec(0, 8'h00, 0, 8'h00, 1, 1, 7'd0, 8'h00);  // dual pop counts once
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s_tx, vecs[i].d_tx, vecs[i].s_rx, vecs[i].d_rx,
           vecs[i].g_tx, vecs[i].g_rx, vecs[i].fl, vecs[i].cl);
      check_state($sformatf("vec%0d", i), vecs[i].exp_occ, vecs[i].exp_head);
    end

    // Fill to full starting at wptr=5, so the write pointer wraps the storage.
    for (int i = 0; i < 64; i++) begin
      push_tx(8'(i));
    end
    check_state("full", 7'd64, 8'h00);
    push_tx(8'hFF);
    check_state("push_at_full", 7'd64, 8'h00);
    for (int i = 0; i < 10; i++) begin
      pop_tx();
      check_state($sformatf("pop10_%0d", i), 7'(63 - i), 8'(i + 1));
    end
    for (int i = 0; i < 10; i++) begin
      push_tx(8'h80 + 8'(i));
      check({"refill occ"}, {1'b0, bus.buffer_occupancy}, 8'(55 + i));
    end
    step(1'b1, 8'hC0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("push_pop_full", 7'd64, 8'd11);

    // scoreboard: expected drain order after the wrap
    for (int v = 11; v < 64; v++) exp_q.push_back(8'(v));
    for (int v = 0; v < 10; v++) exp_q.push_back(8'h80 + 8'(v));
    exp_q.push_back(8'hC0);
    while (exp_q.size() > 0) begin
      check("drain head", bus.tx_packet_data, exp_q.pop_front());
      pop_tx();
    end
    check("drained occ", {1'b0, bus.buffer_occupancy}, 8'd0);

    // clear beats a push
    for (int i = 0; i < 20; i++) push_tx(8'h20 + 8'(i));
    check("occ20", {1'b0, bus.buffer_occupancy}, 8'd20);
    step(1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clear occ", {1'b0, bus.buffer_occupancy}, 8'd0);
    push_tx(8'h42);
    check_state("after_clear_push", 7'd1, 8'h42);

    // flush beats push+pop; mem[0] keeps 0x42
    for (int i = 0; i < 19; i++) push_tx(8'h60 + 8'(i));
    check("occ20b", {1'b0, bus.buffer_occupancy}, 8'd20);
    step(1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check_state("flush", 7'd0, 8'h42);
    push_tx(8'h43);
    check_state("after_flush_push", 7'd1, 8'h43);

    // asynchronous reset mid-cycle, no edge needed
    push_tx(8'h77);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check_state("async_reset", 7'd0, 8'h00);
    #3 n_rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("post_reset_pop", 7'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_usb_data_buffer
